// File: rtl/alu_pkg.sv
// Shared encodings for the pipelined ALU: op types, ARM data-proc opcodes,
// shift types and NZCV flag bit positions.
package alu_pkg;
  localparam logic [3:0] TYPE_DP  = 4'b0000;
  localparam logic [3:0] TYPE_BR  = 4'b0001;
  localparam logic [3:0] TYPE_MUL = 4'b0011;

  localparam logic [3:0] OP_AND = 4'h0;
  localparam logic [3:0] OP_EOR = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_RSB = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_ADC = 4'h5;
  localparam logic [3:0] OP_SBC = 4'h6;
  localparam logic [3:0] OP_RSC = 4'h7;
  localparam logic [3:0] OP_TST = 4'h8;
  localparam logic [3:0] OP_TEQ = 4'h9;
  localparam logic [3:0] OP_CMP = 4'hA;
  localparam logic [3:0] OP_CMN = 4'hB;
  localparam logic [3:0] OP_ORR = 4'hC;
  localparam logic [3:0] OP_MOV = 4'hD;
  localparam logic [3:0] OP_BIC = 4'hE;
  localparam logic [3:0] OP_MVN = 4'hF;

  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // TST/TEQ/CMP/CMN only set flags, they never write a register
  function automatic logic isCompare(input logic [3:0] op);
    return op[3:2] == 2'b10;
  endfunction
endpackage

// File: rtl/alu_barrel_shifter.sv
// Combinational ARM-style barrel shifter with shifter carry-out.
// Amounts of DATA_W and beyond follow the ARM register-shift rules.
module alu_barrel_shifter
  import alu_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 8
) (
  input  logic [DATA_W-1:0]  value,
  input  logic [1:0]         shiftType,
  input  logic [SHAMT_W-1:0] amount,
  input  logic               carryIn,
  output logic [DATA_W-1:0]  result,
  output logic               carryOut
);
  localparam int unsigned W = DATA_W;

  int unsigned n, r;
  logic [DATA_W:0] ext;

  // Shifting through a one-bit extension yields the last bit shifted out,
  // which also covers the n == DATA_W and n > DATA_W cases directly.
  always_comb begin
    n        = 32'(amount);
    r        = n % W;
    ext      = '0;
    result   = value;
    carryOut = carryIn;
    if (n != 0) begin
      unique case (shiftType)
        SH_LSL: {carryOut, result} = {1'b0, value} << n;
        SH_LSR: {result, carryOut} = {value, 1'b0} >> n;
        SH_ASR: begin
          ext = $signed({value, 1'b0}) >>> n;
          {result, carryOut} = ext;
        end
        default: begin
          if (r == 0) carryOut = value[DATA_W-1];
          else begin
            result   = (value >> r) | (value << (W - r));
            carryOut = result[DATA_W-1];
          end
        end
      endcase
    end
  end
endmodule

// File: rtl/alu_pipe.sv
// Two-stage ALU: S1 registers the shifted operand, S2 is the output register.
// Define ALU_MUL_EN to support type 0011 (MUL); otherwise it reports out_err.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 8,
  parameter int OFF_W   = 24,
  parameter int TAG_W   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         in_type,
  input  logic [3:0]         in_opcode,
  input  logic               in_set_flags,
  input  logic [DATA_W-1:0]  in_op_a,
  input  logic [DATA_W-1:0]  in_op_b,
  input  logic [1:0]         in_shift_type,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_result,
  output logic               out_wr_en,
  output logic [3:0]         out_flags,
  output logic [TAG_W-1:0]   out_tag,
  output logic               out_err
);
  typedef struct packed {
    logic [3:0]        opType;
    logic [3:0]        opcode;
    logic              setFlags;
    logic [DATA_W-1:0] opA;
    logic [DATA_W-1:0] opB;
    logic              shCarry;
    logic              shZero;
    logic [TAG_W-1:0]  tag;
  } s1_t;

  s1_t               s1, s1Next;
  logic [2:1]        vldPipe;
  logic              s2Adv;
  logic [3:0]        flagsReg, flagsNext;
  logic [DATA_W-1:0] shRes;
  logic              shCarry;

  alu_barrel_shifter #(.DATA_W(DATA_W), .SHAMT_W(SHAMT_W)) uShift (
    .value    (in_op_b),
    .shiftType(in_shift_type),
    .amount   (in_shamt),
    .carryIn  (flagsReg[FLAG_C]),
    .result   (shRes),
    .carryOut (shCarry)
  );

  assign s2Adv     = !vldPipe[2] || out_ready;
  assign in_ready  = !vldPipe[1] || s2Adv;
  assign out_valid = vldPipe[2];
  assign out_flags = flagsReg;

  // A zero shift keeps C; that C is resolved in S2 so it sees the op ahead.
  always_comb begin
    s1Next.opType   = in_type;
    s1Next.opcode   = in_opcode;
    s1Next.setFlags = in_set_flags;
    s1Next.opA      = in_op_a;
    s1Next.opB      = (in_type == TYPE_DP) ? shRes : in_op_b;
    s1Next.shCarry  = shCarry;
    s1Next.shZero   = (in_shamt == '0);
    s1Next.tag      = in_tag;
  end

  logic [DATA_W-1:0] addX, addY, dpRes, resNext, offExt;
  logic [DATA_W:0]   sum;
  logic              addCin, isArith, cIn, shC, ovf, wrNext, errNext;
  logic signed [OFF_W-1:0] offS;
`ifdef ALU_MUL_EN
  logic [DATA_W-1:0] mulRes;
`endif

  // Subtracts are a + ~b + carry, so C comes out as NOT borrow directly.
  always_comb begin
    cIn     = flagsReg[FLAG_C];
    shC     = s1.shZero ? cIn : s1.shCarry;
    addX    = s1.opA;
    addY    = s1.opB;
    addCin  = 1'b0;
    isArith = 1'b1;
    unique case (s1.opcode)
      OP_SUB, OP_CMP: begin addY = ~s1.opB; addCin = 1'b1; end
      OP_RSB:         begin addX = s1.opB; addY = ~s1.opA; addCin = 1'b1; end
      OP_ADD, OP_CMN: ;
      OP_ADC:         addCin = cIn;
      OP_SBC:         begin addY = ~s1.opB; addCin = cIn; end
      OP_RSC:         begin addX = s1.opB; addY = ~s1.opA; addCin = cIn; end
      default:        isArith = 1'b0;
    endcase
    sum = {1'b0, addX} + {1'b0, addY} + (DATA_W+1)'(addCin);
    ovf = (addX[DATA_W-1] == addY[DATA_W-1]) && (sum[DATA_W-1] != addX[DATA_W-1]);

    unique case (s1.opcode)
      OP_AND, OP_TST: dpRes = s1.opA & s1.opB;
      OP_EOR, OP_TEQ: dpRes = s1.opA ^ s1.opB;
      OP_ORR:         dpRes = s1.opA | s1.opB;
      OP_MOV:         dpRes = s1.opB;
      OP_BIC:         dpRes = s1.opA & ~s1.opB;
      OP_MVN:         dpRes = ~s1.opB;
      default:        dpRes = sum[DATA_W-1:0];
    endcase

    offS   = s1.opB[OFF_W-1:0];
    offExt = DATA_W'(offS);
`ifdef ALU_MUL_EN
    mulRes = s1.opA * s1.opB;
`endif

    flagsNext = flagsReg;
    resNext   = '0;
    wrNext    = 1'b0;
    errNext   = 1'b0;
    case (s1.opType)
      TYPE_DP: begin
        resNext = dpRes;
        wrNext  = !isCompare(s1.opcode);
        if (s1.setFlags) begin
          flagsNext[FLAG_N] = dpRes[DATA_W-1];
          flagsNext[FLAG_Z] = (dpRes == '0);
          flagsNext[FLAG_C] = isArith ? sum[DATA_W] : shC;
          if (isArith) flagsNext[FLAG_V] = ovf;
        end
      end
      TYPE_BR: begin
        resNext = s1.opA + offExt + DATA_W'(1);
        wrNext  = 1'b1;
      end
`ifdef ALU_MUL_EN
      TYPE_MUL: begin
        resNext = mulRes;
        wrNext  = 1'b1;
        if (s1.setFlags) begin
          flagsNext[FLAG_N] = mulRes[DATA_W-1];
          flagsNext[FLAG_Z] = (mulRes == '0);
        end
      end
`endif
      default: errNext = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vldPipe    <= '0;
      s1         <= '0;
      flagsReg   <= '0;
      out_result <= '0;
      out_wr_en  <= 1'b0;
      out_tag    <= '0;
      out_err    <= 1'b0;
    end else begin
      if (in_ready) begin
        vldPipe[1] <= in_valid;
        if (in_valid) s1 <= s1Next;
      end
      if (s2Adv) begin
        vldPipe[2] <= vldPipe[1];
        if (vldPipe[1]) begin
          out_result <= resNext;
          out_wr_en  <= wrNext;
          out_tag    <= s1.tag;
          out_err    <= errNext;
          flagsReg   <= flagsNext;
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: the driver queues expected responses at
// accept time, a negedge monitor pops and compares each emitted result.
module tb_alu_pipe;
  import alu_pkg::*;

  logic        clk = 1'b0, reset = 1'b1;
  logic        in_valid = 1'b0, in_ready, in_set_flags = 1'b0;
  logic [3:0]  in_type = '0, in_opcode = '0;
  logic [31:0] in_op_a = '0, in_op_b = '0;
  logic [1:0]  in_shift_type = '0;
  logic [7:0]  in_shamt = '0;
  logic [3:0]  in_tag = '0;
  logic        out_valid, out_ready = 1'b1, out_wr_en, out_err;
  logic [31:0] out_result;
  logic [3:0]  out_flags, out_tag;

  alu_pipe #(.DATA_W(32), .SHAMT_W(8), .OFF_W(24), .TAG_W(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_type(in_type), .in_opcode(in_opcode), .in_set_flags(in_set_flags),
    .in_op_a(in_op_a), .in_op_b(in_op_b), .in_shift_type(in_shift_type),
    .in_shamt(in_shamt), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_wr_en(out_wr_en),
    .out_flags(out_flags), .out_tag(out_tag), .out_err(out_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] res;
    logic        wr;
    logic [3:0]  fl;
    logic [3:0]  tag;
    logic        err;
  } exp_t;

`ifdef ALU_MUL_EN
  localparam logic [3:0] FL_END = 4'b0010;
`else
  localparam logic [3:0] FL_END = 4'b1010;
`endif

  exp_t sb[$];
  exp_t monExp, monAct;
  int   compared = 0, mismatched = 0, emitted = 0, accepted = 0, base = 0;
  logic [3:0] tagCnt = 4'd1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic exp_t ex(input logic [31:0] res, input logic wr, input logic [3:0] fl, input logic err);
    exp_t e;
    e.res = res; e.wr = wr; e.fl = fl; e.tag = '0; e.err = err;
    return e;
  endfunction

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      emitted++;
      compared++;
      monAct = {out_result, out_wr_en, out_flags, out_tag, out_err};
      if (sb.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_output: got tag %0d result %h, want no output", out_tag, out_result);
      end else begin
        monExp = sb.pop_front();
        if (monAct !== monExp) begin
          mismatched++;
          $display("FAIL result_tag%0d: got res=%h wr=%b nzcv=%b tag=%0d err=%b want res=%h wr=%b nzcv=%b tag=%0d err=%b",
                   monExp.tag, monAct.res, monAct.wr, monAct.fl, monAct.tag, monAct.err,
                   monExp.res, monExp.wr, monExp.fl, monExp.tag, monExp.err);
        end
      end
    end
  end

  // Presents one op, waits (bounded) for acceptance, queues its expectation.
  task automatic send(input logic [3:0] ty, input logic [3:0] op, input logic s,
                      input logic [31:0] a, input logic [31:0] b, input logic [1:0] st,
                      input logic [7:0] sa, input exp_t e, input bit push);
    int waitCyc = 0;
    in_type = ty; in_opcode = op; in_set_flags = s; in_op_a = a; in_op_b = b;
    in_shift_type = st; in_shamt = sa; in_tag = tagCnt; in_valid = 1'b1;
    e.tag = tagCnt;
    do begin @(negedge clk); waitCyc++; end while (!in_ready && waitCyc < 50);
    if (!in_ready) begin
      compared++; mismatched++;
      $display("FAIL accept_timeout: got in_ready=0 for 50 cycles want 1");
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    accepted++;
    if (push) sb.push_back(e);
    tagCnt++;
    #1 in_valid = 1'b0;
  endtask

  task automatic dp(input logic [3:0] op, input logic s, input logic [31:0] a, input logic [31:0] b,
                    input logic [1:0] st, input logic [7:0] sa,
                    input logic [31:0] res, input logic wr, input logic [3:0] fl);
    send(TYPE_DP, op, s, a, b, st, sa, ex(res, wr, fl, 1'b0), 1'b1);
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || out_valid) && n < 100) begin @(posedge clk); n++; end
    check("drain_left", sb.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_flags", out_flags, 0);
    check("rst_out_result", out_result, 0);
    check("rst_out_wr_err", {out_wr_en, out_err}, 0);
    check("rst_out_tag", out_tag, 0);
    @(posedge clk); #1 reset = 1'b0;

    // Result appears two clock edges after the op is presented
    dp(OP_ADD, 1'b1, 32'h7FFFFFFF, 32'h1, SH_LSL, 8'd0, 32'h80000000, 1'b1, 4'b1001);
    @(negedge clk); check("latency_edge1_valid", out_valid, 0);
    @(negedge clk); check("latency_edge2_valid", out_valid, 1);
    @(posedge clk); #1;

    dp(OP_AND, 1'b1, 32'hFF, 32'h0F, SH_LSL, 8'd0, 32'h0F, 1'b1, 4'b0001);
    dp(OP_CMP, 1'b1, 32'd5, 32'd5, SH_LSL, 8'd0, 32'h0, 1'b0, 4'b0110);
    dp(OP_SUB, 1'b1, 32'd3, 32'd5, SH_LSL, 8'd0, 32'hFFFFFFFE, 1'b1, 4'b1000);
    dp(OP_SBC, 1'b1, 32'd10, 32'd3, SH_LSL, 8'd0, 32'd6, 1'b1, 4'b0010);
    dp(OP_RSC, 1'b1, 32'd5, 32'd2, SH_LSL, 8'd0, 32'hFFFFFFFD, 1'b1, 4'b1000);
    dp(OP_MOV, 1'b1, 32'h0, 32'h80000000, SH_LSR, 8'd32, 32'h0, 1'b1, 4'b0110);
    dp(OP_MOV, 1'b1, 32'h0, 32'h1, SH_ROR, 8'd0, 32'h1, 1'b1, 4'b0010);
    dp(OP_ADD, 1'b1, 32'hFFFFFFFF, 32'h1, SH_LSL, 8'd0, 32'h0, 1'b1, 4'b0110);
    dp(OP_ADC, 1'b0, 32'h1, 32'h1, SH_LSL, 8'd0, 32'h3, 1'b1, 4'b0110);
    dp(OP_MOV, 1'b1, 32'h0, 32'h1, SH_LSL, 8'd32, 32'h0, 1'b1, 4'b0110);
    dp(OP_MOV, 1'b1, 32'h0, 32'h80000001, SH_LSL, 8'd33, 32'h0, 1'b1, 4'b0100);
    dp(OP_MOV, 1'b1, 32'h0, 32'h80000000, SH_ASR, 8'd40, 32'hFFFFFFFF, 1'b1, 4'b1010);
    dp(OP_MOV, 1'b1, 32'h0, 32'h80000001, SH_ROR, 8'd64, 32'h80000001, 1'b1, 4'b1010);
    dp(OP_MOV, 1'b1, 32'h0, 32'h3, SH_LSL, 8'd1, 32'h6, 1'b1, 4'b0000);
    dp(OP_MOV, 1'b1, 32'h0, 32'hF8, SH_ROR, 8'd4, 32'h8000000F, 1'b1, 4'b1010);
    send(TYPE_BR, OP_ADD, 1'b1, 32'h100, 32'hAAFFFFFE, SH_LSL, 8'd4, ex(32'hFF, 1'b1, 4'b1010, 1'b0), 1'b1);
    send(4'b0111, OP_MOV, 1'b1, 32'h5, 32'h7, SH_LSL, 8'd0, ex(32'h0, 1'b0, 4'b1010, 1'b1), 1'b1);
`ifdef ALU_MUL_EN
    send(TYPE_MUL, OP_MOV, 1'b1, 32'd3, 32'd5, SH_LSL, 8'd2, ex(32'd15, 1'b1, FL_END, 1'b0), 1'b1);
`else
    send(TYPE_MUL, OP_MOV, 1'b1, 32'd3, 32'd5, SH_LSL, 8'd2, ex(32'h0, 1'b0, FL_END, 1'b1), 1'b1);
`endif
    drain();

    // Backpressure: two ops fill the pipe, the rest wait, order is kept
    tagCnt = 4'd1;
    base = accepted;
    fork
      begin
        for (int i = 1; i <= 4; i++)
          dp(OP_MOV, 1'b0, 32'h0, 32'(i * 17), SH_LSL, 8'd0, 32'(i * 17), 1'b1, FL_END);
      end
      begin
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("stall_in_ready", in_ready, 0);
        check("stall_accepted", accepted - base, 2);
        @(posedge clk); #1 out_ready = 1'b1;
      end
    join
    drain();

    // Reset with two ops in flight; the op presented during reset is dropped
    out_ready = 1'b0;
    send(TYPE_DP, OP_MOV, 1'b0, 32'h0, 32'hAA, SH_LSL, 8'd0, ex(32'h0, 1'b0, 4'b0, 1'b0), 1'b0);
    send(TYPE_DP, OP_MOV, 1'b0, 32'h0, 32'hBB, SH_LSL, 8'd0, ex(32'h0, 1'b0, 4'b0, 1'b0), 1'b0);
    reset = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1 reset = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_flags", out_flags, 0);
    check("reset_in_ready", in_ready, 1);
    out_ready = 1'b1;
    base = emitted;
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("post_reset_emitted", emitted - base, 0);
    check("sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
